friscv_fetch_unit: RTL
======================

// Module: friscv_fetch_unit
// PURPOSE
// - Parametrised instruction-fetch stage for the next-generation friscv core.
// - Owns the PC and issues word fetches to a sync-read instruction SRAM (1-cycle latency).
// - Buffers {pc, instr} pairs in a prefetch FIFO; hands them to decode via valid/ready.
// - Supports branch/jump redirect with flush, plus a halt/drain mode.
// - Replaces the fixed single-cycle PC + PC-source mux path.
// PARAMETERS
// - ARCH        32            data/address width (friscv_pkg::ARCH)
// - FIFO_DEPTH  2             prefetch entries; >=2 required for 1 instr/cycle sustained
// - RESET_PC    32'h0000_0000 PC loaded on reset; must be 4-byte aligned
// PORTS
// - clk              in   1     core clock, all logic on rising edge
// - rst_n            in   1     synchronous, active-low reset
// - redirect_in      in   1     branch/jump taken; flush and load new PC
// - redirect_pc_in   in   ARCH  redirect target byte address
// - halt_in          in   1     stop issuing new fetches while high
// - imem_req_out     out  1     fetch request this cycle
// - imem_addr_out    out  ARCH  byte address of fetch (= pc_q)
// - imem_rdata_in    in   ARCH  instruction word, valid the cycle after imem_req_out
// - instr_valid_out  out  1     FIFO head valid
// - instr_ready_in   in   1     decode accepts head
// - instr_out        out  ARCH  head instruction
// - instr_pc_out     out  ARCH  head PC
// - halted_out       out  1     state==HALTED
// - misalign_err_out out  1     1-cycle pulse: redirect target had addr[1:0]!=0
// BEHAVIOUR
// - Reset (rst_n==0 at edge):
//   - pc_q=RESET_PC; FIFO empty; inflight=0; state=RUN.
//   - All outputs 0 except imem_addr_out=RESET_PC.
// - Issue condition (comb):
//   - issue = state==RUN && !halt_in && !redirect_in && (count + inflight - pop) < FIFO_DEPTH.
//   - pop = instr_valid_out && instr_ready_in.
//   - On issue: imem_req_out=1, imem_addr_out=pc_q; req_pc_q<=pc_q; pc_q<=pc_q+4.
//   - PC wraps modulo 2^ARCH.
// - Response:
//   - inflight<=issue.
//   - If inflight && !redirect_in, push {req_pc_q, imem_rdata_in} at that edge.
//   - Push never overflows, guaranteed by the issue condition.
// - Output:
//   - FIFO is show-ahead; instr_valid_out = count!=0, registered state only.
//   - Simultaneous push+pop legal at any count.
// - Latency:
//   - Issue at t -> push at end of t+1 -> instr_valid_out at t+2.
//   - Steady state with ready=1: one instr/cycle, consecutive PCs.
// - Redirect (priority over everything except reset):
//   - FIFO cleared; inflight response discarded; no issue that cycle.
//   - pc_q <= {redirect_pc_in[ARCH-1:2],2'b00}.
//   - A valid&ready handshake in the redirect cycle is void.
//   - If redirect_pc_in[1:0]!=0: misalign_err_out=1 next cycle, else 0.
//   - Redirect at t -> first issue t+1 (if not halted) -> valid t+3.
// - FSM (fetch_state_e):
//   - RUN -> DRAIN when halt_in=1.
//   - DRAIN -> HALTED when inflight==0 (same edge if already 0).
//   - DRAIN/HALTED -> RUN when halt_in=0.
//   - FIFO keeps draining to decode in every state.
//   - Redirect in DRAIN/HALTED updates pc_q and flushes, but does not resume fetching.
// - Back-pressure: instr_ready_in=0 holds head stable; issue stops once count+inflight==FIFO_DEPTH.
// STRUCTURE
// - friscv_pkg additions:
//   - typedef enum logic [1:0] {RUN, DRAIN, HALTED} fetch_state_e;
//   - typedef struct packed {logic [ARCH-1:0] pc, instr;} fetch_entry_t;
// - Sub-module friscv_sync_fifo #(WIDTH, DEPTH):
//   - Ports: push, pop, flush, show-ahead dout, count, sync rst_n.
//   - Count width $clog2(DEPTH+1).
//   - Instantiated with WIDTH=$bits(fetch_entry_t).
// - Top level holds pc_q, req_pc_q, inflight, FSM, issue logic.
// TESTING
// - Reset release, ready=1, imem returns addr as data:
//   - req at 0x0,0x4,0x8...; valid from cycle 2; one pc/instr per cycle, no gaps.
// - ready=0 for 10 cycles, FIFO_DEPTH=2:
//   - exactly 2 requests issued, then imem_req_out=0.
//   - head stays pc=0x0; on ready=1, order 0x0,0x4,0x8 preserved.
// - Redirect to 0x100 while FIFO full and a request is inflight:
//   - stale entries never presented.
//   - next request addr 0x100 at t+1; valid pc=0x100 at t+3.
// - Redirect to 0x102:
//   - misalign_err_out pulses once next cycle; fetch resumes at 0x100.
// - halt_in=1 mid-stream:
//   - DRAIN then HALTED once inflight=0; halted_out=1; FIFO drains; no requests.
//   - halt_in=0: resumes at next sequential PC.
// - Wrap-around and mid-op reset:
//   - pc=0xFFFF_FFFC fetch -> next addr 0x0.
//   - rst_n=0 with full FIFO: all outputs 0, next request RESET_PC.

Source files
------------

// File: rtl/friscv_pkg.sv
// Shared types and widths for the friscv core.
package friscv_pkg;

  localparam int ARCH = 32;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} fetch_state_e;

  typedef struct packed {
    logic [ARCH-1:0] pc;
    logic [ARCH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/friscv_sync_fifo.sv
// Show-ahead synchronous FIFO with flush; dout is the head entry whenever count != 0.
module friscv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_en, push_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop frees a slot in the same cycle, so push+pop is legal even when full.
  assign pop_en  = pop && (count_q != '0);
  assign push_en = push && ((count_q != CNT_W'(DEPTH)) || pop_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_en)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/friscv_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches to a 1-cycle SRAM and
// queues {pc, instr} pairs for decode. Handshake: an entry transfers to decode on
// any rising edge where instr_valid_out && instr_ready_in, except in a redirect cycle.
module friscv_fetch_unit
  import friscv_pkg::*;
#(
  parameter int              FIFO_DEPTH = 2,
  parameter logic [ARCH-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_in,
  input  logic [ARCH-1:0] redirect_pc_in,
  input  logic            halt_in,
  output logic            imem_req_out,
  output logic [ARCH-1:0] imem_addr_out,
  input  logic [ARCH-1:0] imem_rdata_in,
  output logic            instr_valid_out,
  input  logic            instr_ready_in,
  output logic [ARCH-1:0] instr_out,
  output logic [ARCH-1:0] instr_pc_out,
  output logic            halted_out,
  output logic            misalign_err_out,
  output fetch_state_e    state_dbg_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic [ARCH-1:0] pc_q, pc_d;
  logic [ARCH-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            misalign_q, misalign_d;
  fetch_state_e    state_q, state_d;

  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     head, new_entry;
  logic             pop, issue;
  logic [OCC_W-1:0] occupancy;

  assign instr_valid_out = (fifo_count != '0);
  assign pop             = instr_valid_out && instr_ready_in;

  // Slots already promised: queued entries plus the response in flight, minus what leaves now.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign issue     = rst_n && (state_q == RUN) && !halt_in && !redirect_in &&
                     (occupancy < OCC_W'(FIFO_DEPTH));

  assign new_entry.pc    = req_pc_q;
  assign new_entry.instr = imem_rdata_in;

  friscv_sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(redirect_in),
    .push (inflight_q && !redirect_in),
    .din  (new_entry),
    .pop  (pop && !redirect_in),
    .dout (head),
    .count(fifo_count)
  );

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    misalign_d = redirect_in && (redirect_pc_in[1:0] != 2'b00);
    state_d    = state_q;

    if (redirect_in)  pc_d = {redirect_pc_in[ARCH-1:2], 2'b00};
    else if (issue)   pc_d = pc_q + ARCH'(4);
    if (issue)        req_pc_d = pc_q;

    // DRAIN only waits for the last outstanding response; skip it if none is pending.
    unique case (state_q)
      RUN:     if (halt_in) state_d = inflight_q ? DRAIN : HALTED;
      DRAIN:   if (!halt_in) state_d = RUN;
               else if (!inflight_q) state_d = HALTED;
      HALTED:  if (!halt_in) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      misalign_q <= 1'b0;
      state_q    <= RUN;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      misalign_q <= misalign_d;
      state_q    <= state_d;
    end
  end

  assign imem_req_out     = issue;
  assign imem_addr_out    = pc_q;
  assign instr_out        = instr_valid_out ? head.instr : '0;
  assign instr_pc_out     = instr_valid_out ? head.pc    : '0;
  assign halted_out       = (state_q == HALTED);
  assign misalign_err_out = misalign_q;
  assign state_dbg_out    = state_q;

endmodule
